// File: rtl/sudoku_vga_pkg.sv
// Shared types, colour constants and grid geometry for the sudoku VGA board renderer.
package sudoku_vga_pkg;

    localparam int unsigned GRID_N = 9;

    localparam logic [11:0] COL_BG     = 12'h223;
    localparam logic [11:0] COL_LINE   = 12'h555;
    localparam logic [11:0] COL_CELL   = 12'hFFF;
    localparam logic [11:0] COL_CURSOR = 12'hFE8;
    localparam logic [11:0] COL_GIVEN  = 12'h008;
    localparam logic [11:0] COL_USER   = 12'h0A0;
    localparam logic [11:0] COL_MENU   = 12'h36C;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        logic   given;
        digit_t digit;
    } cell_t;

    // Every third gap is a thick block line, so origins shift by the extra width per block.
    function automatic int unsigned cell_origin(int unsigned k, int unsigned cell_size,
                                                int unsigned cell_gap, int unsigned block_gap);
        return k * (cell_size + cell_gap) + (k / 3) * (block_gap - cell_gap);
    endfunction

endpackage

// File: rtl/sudoku_glyph_rom.sv
// Synchronous 1-bit glyph ROM: ten seven-segment digits, one CELL_SIZE x CELL_SIZE bitmap each.
module sudoku_glyph_rom #(
    parameter int unsigned CELL_SIZE = 52,
    parameter int unsigned ADDR_W    = $clog2(10 * CELL_SIZE * CELL_SIZE)
) (
    input  logic              clka,
    input  logic [ADDR_W-1:0] addr,
    output logic              dout
);

    localparam int unsigned AREA = CELL_SIZE * CELL_SIZE;
    localparam int unsigned L    = CELL_SIZE / 4;
    localparam int unsigned R    = CELL_SIZE - 1 - CELL_SIZE / 4;
    localparam int unsigned T    = CELL_SIZE / 8;
    localparam int unsigned TP   = CELL_SIZE / 8;
    localparam int unsigned B    = CELL_SIZE - 1 - CELL_SIZE / 8;
    localparam int unsigned M    = CELL_SIZE / 2;

    // Segment order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_mask(int unsigned d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    int unsigned a_i, d_i, x_i, y_i;
    logic [6:0]  seg;
    logic        span_h, col_l, col_r, row_top, row_mid, row_bot, half_up, half_lo, bit_d;

    always_comb begin
        a_i     = 32'(addr);
        d_i     = a_i / AREA;
        y_i     = (a_i % AREA) / CELL_SIZE;
        x_i     = a_i % CELL_SIZE;
        seg     = seg_mask(d_i);
        span_h  = (x_i >= L) && (x_i <= R);
        col_l   = (x_i >= L) && (x_i < L + T);
        col_r   = (x_i > R - T) && (x_i <= R);
        row_top = (y_i >= TP) && (y_i < TP + T);
        row_mid = (y_i >= M - T / 2) && (y_i < M - T / 2 + T);
        row_bot = (y_i > B - T) && (y_i <= B);
        half_up = (y_i >= TP) && (y_i <= M);
        half_lo = (y_i >= M) && (y_i <= B);
        bit_d   = (seg[6] & span_h & row_top) | (seg[5] & col_r & half_up) |
                  (seg[4] & col_r & half_lo) | (seg[3] & span_h & row_bot) |
                  (seg[2] & col_l & half_lo) | (seg[1] & col_l & half_up) |
                  (seg[0] & span_h & row_mid);
    end

    always_ff @(posedge clka) begin
        dout <= bit_d;
    end

endmodule

// File: rtl/sudoku_board_renderer.sv
// 9x9 sudoku board pixel renderer, 3-cycle pipeline aligned with the glyph ROM.
// Optional SUDOKU_CURSOR_BLINK_EN: cursor highlight blinks every BLINK_FRAMES frames.
module sudoku_board_renderer
    import sudoku_vga_pkg::*;
#(
    parameter int unsigned CELL_SIZE    = 52,
    parameter int unsigned CELL_GAP     = 1,
    parameter int unsigned BLOCK_GAP    = 3,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned COLOR_W      = 12
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               in_valid,
    input  logic               stage,
    input  logic               wr_en,
    input  logic [3:0]         wr_row,
    input  logic [3:0]         wr_col,
    input  logic [3:0]         wr_digit,
    input  logic               wr_given,
    input  logic               clr,
    input  logic [3:0]         cur_row,
    input  logic [3:0]         cur_col,
    output logic [COLOR_W-1:0] pixel,
    output logic               pixel_vld
);

    localparam int unsigned GRID_END =
        cell_origin(GRID_N - 1, CELL_SIZE, CELL_GAP, BLOCK_GAP) + CELL_SIZE;
    localparam int unsigned OFF_W  = $clog2(CELL_SIZE + BLOCK_GAP);
    localparam int unsigned ROM_AW = $clog2(10 * CELL_SIZE * CELL_SIZE);

    logic       hl_active;
    logic [3:0] h_idx, v_idx;
    logic [9:0] h_off, v_off;
    logic       h_line, v_line, in_grid, cur_hit;

    // Largest origin not above the counter selects the cell; overshoot past CELL_SIZE is a line.
    always_comb begin
        h_idx = '0;
        v_idx = '0;
        h_off = h_cnt;
        v_off = v_cnt;
        for (int unsigned k = 0; k < GRID_N; k++) begin
            if (32'(h_cnt) >= cell_origin(k, CELL_SIZE, CELL_GAP, BLOCK_GAP)) begin
                h_idx = 4'(k);
                h_off = h_cnt - 10'(cell_origin(k, CELL_SIZE, CELL_GAP, BLOCK_GAP));
            end
            if (32'(v_cnt) >= cell_origin(k, CELL_SIZE, CELL_GAP, BLOCK_GAP)) begin
                v_idx = 4'(k);
                v_off = v_cnt - 10'(cell_origin(k, CELL_SIZE, CELL_GAP, BLOCK_GAP));
            end
        end
        h_line  = 32'(h_off) >= CELL_SIZE;
        v_line  = 32'(v_off) >= CELL_SIZE;
        in_grid = (32'(h_cnt) < GRID_END) && (32'(v_cnt) < GRID_END);
        cur_hit = hl_active && (cur_row < 4'(GRID_N)) && (cur_col < 4'(GRID_N)) &&
                  (cur_row == v_idx) && (cur_col == h_idx);
    end

    logic             s1_vld, s1_stage, s1_grid, s1_line, s1_cur;
    logic [3:0]       s1_row, s1_col;
    logic [OFF_W-1:0] s1_x, s1_y;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_stage <= 1'b0;
            s1_grid  <= 1'b0;
            s1_line  <= 1'b0;
            s1_cur   <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_vld   <= in_valid;
            s1_stage <= stage;
            s1_grid  <= in_grid;
            s1_line  <= h_line | v_line;
            s1_cur   <= cur_hit;
            s1_row   <= v_idx;
            s1_col   <= h_idx;
            s1_x     <= h_off[OFF_W-1:0];
            s1_y     <= v_off[OFF_W-1:0];
        end
    end

    cell_t board [GRID_N][GRID_N];
    cell_t wr_cur;
    logic  wr_in_range, wr_ok;

    // Locked (given) cells only accept a write that is itself a puzzle load.
    always_comb begin
        wr_in_range = (wr_row < 4'(GRID_N)) && (wr_col < 4'(GRID_N)) && (wr_digit <= 4'd9);
        wr_cur      = wr_in_range ? board[wr_row][wr_col] : '0;
        wr_ok       = wr_en && wr_in_range && (!wr_cur.given || wr_given);
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < GRID_N; r++)
                for (int c = 0; c < GRID_N; c++)
                    board[r][c] <= '0;
        end else if (clr) begin
            for (int r = 0; r < GRID_N; r++)
                for (int c = 0; c < GRID_N; c++)
                    board[r][c] <= '0;
        end else if (wr_ok) begin
            board[wr_row][wr_col] <= '{given: wr_given, digit: wr_digit};
        end
    end

    cell_t             rd_cell;
    logic [ROM_AW-1:0] rom_addr;
    logic              glyph_bit;

    always_comb begin
        rd_cell  = board[s1_row][s1_col];
        rom_addr = ROM_AW'(32'(rd_cell.digit) * CELL_SIZE * CELL_SIZE +
                           32'(s1_y) * CELL_SIZE + 32'(s1_x));
    end

    sudoku_glyph_rom #(
        .CELL_SIZE (CELL_SIZE),
        .ADDR_W    (ROM_AW)
    ) u_glyph_rom (
        .clka (clka),
        .addr (rom_addr),
        .dout (glyph_bit)
    );

    logic s2_vld, s2_stage, s2_grid, s2_line, s2_cur, s2_nz, s2_given;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_stage <= 1'b0;
            s2_grid  <= 1'b0;
            s2_line  <= 1'b0;
            s2_cur   <= 1'b0;
            s2_nz    <= 1'b0;
            s2_given <= 1'b0;
        end else begin
            s2_vld   <= s1_vld;
            s2_stage <= s1_stage;
            s2_grid  <= s1_grid;
            s2_line  <= s1_line;
            s2_cur   <= s1_cur;
            s2_nz    <= rd_cell.digit != '0;
            s2_given <= rd_cell.given;
        end
    end

    logic [11:0] colour;

    always_comb begin
        colour = COL_CELL;
        if (!s2_stage)                colour = COL_MENU;
        else if (!s2_grid)            colour = COL_BG;
        else if (s2_line)             colour = COL_LINE;
        else if (glyph_bit && s2_nz)  colour = s2_given ? COL_GIVEN : COL_USER;
        else if (s2_cur)              colour = COL_CURSOR;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pixel     <= '0;
            pixel_vld <= 1'b0;
        end else begin
            pixel     <= s2_vld ? COLOR_W'(colour) : '0;
            pixel_vld <= s2_vld;
        end
    end

`ifdef SUDOKU_CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (in_valid && h_cnt == '0 && v_cnt == '0) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign hl_active = blink_phase;
`else
    // A zero blink period degenerates to no highlight; any real period means steady.
    assign hl_active = (BLINK_FRAMES != 0);
`endif

endmodule
